fb_scanout_ctrl: RTL and testbench
==================================

FB_SCANOUT_CTRL -- requirements
Module: fb_scanout_ctrl

Interface
REQ-001 SHALL have parameter H_OFF, default 59, first active horc of the 448-pixel CHIP-8 window.
REQ-002 SHALL have parameter V_OFF, default 20, first active vertc of the 256-line CHIP-8 window.
REQ-003 SHALL have parameter FG_COLOR, default 16'hFFFF, RGB565 colour for a set pixel.
REQ-004 SHALL have parameter BG_COLOR, default 16'h0000, RGB565 colour for a clear pixel or outside the window.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports horc, vertc  in  10 each  counters from the LCD timing generator.
REQ-008 SHALL have ports de, hsync, vsync  in  1 each  timing-generator outputs.
REQ-009 SHALL have ports de_o, hsync_o, vsync_o  out  1 each  inputs delayed 1 cycle, aligned with rgb.
REQ-010 SHALL have port rgb  out  16  registered pixel colour.
REQ-011 SHALL have port frame_tick  out  1  one-cycle pulse per frame (CHIP-8 60 Hz timer source).
REQ-012 SHALL have ports fb_addr out 8, fb_we out 1, fb_wdata out 8, fb_rdata in 8  single-port framebuffer RAM with 1-cycle synchronous read.
REQ-013 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in 8, cpu_wdata in 8  CPU access request.
REQ-014 SHALL have ports cpu_gnt out 1, cpu_rdata out 8, cpu_rvalid out 1  CPU grant and read return.

Function
REQ-015 Framebuffer SHALL be 64x32 pixels, byte address = row*8 + col[5:3], byte bit 7 = leftmost pixel.
REQ-016 Fetch trigger SHALL be horc==0 with V_OFF <= vertc < V_OFF+256; CHIP-8 row = (vertc-V_OFF)>>3.
REQ-017 State machine SHALL have states IDLE and FETCH; trigger moves IDLE->FETCH, and FETCH returns to IDLE after issuing 8 reads (addresses row*8+0..7, one per cycle).
REQ-018 Each fetched byte (valid 1 cycle after its read) SHALL be loaded into the 64-bit line buffer; the buffer is complete 9 cycles after the trigger.
REQ-019 Display fetch SHALL have absolute priority: cpu_gnt=0 in FETCH and in the trigger cycle.
REQ-020 cpu_gnt SHALL be combinational = cpu_req in IDLE with no trigger; while granted, fb_addr/fb_we/fb_wdata SHALL be driven from cpu_addr/cpu_we/cpu_wdata.
REQ-021 CPU SHALL hold cpu_req and its fields stable until cpu_gnt; one access per granted cycle.
REQ-022 Granted read SHALL give cpu_rvalid=1 with cpu_rdata=fb_rdata exactly one cycle after grant; granted write SHALL give no cpu_rvalid.
REQ-023 fb_we SHALL be 0 whenever the CPU is not granted.
REQ-024 Column tracking SHALL use a sub-pixel counter 0..6 and a column counter 0..63, both cleared at horc==H_OFF; column increments when sub-pixel wraps 6->0.
REQ-025 Window SHALL be H_OFF <= horc < H_OFF+448 and V_OFF <= vertc < V_OFF+256, with de=1.
REQ-026 rgb SHALL be registered: FG_COLOR if inside window and line-buffer bit for current column set, else BG_COLOR.
REQ-027 frame_tick SHALL pulse one cycle when horc==0 and vertc==V_OFF+256.
REQ-028 Line buffer SHALL not change except during FETCH; no torn line within the window.

Reset
REQ-029 On rst_n=0 SHALL force: state IDLE, line buffer 0, counters 0, rgb=BG_COLOR, de_o/hsync_o/vsync_o/frame_tick/cpu_gnt/cpu_rvalid/fb_we=0, cpu_rdata=0, fb_addr=0.
REQ-030 Reset mid-FETCH SHALL abort the fetch; the next trigger after release SHALL refetch normally.

Verification
REQ-031 Fill RAM byte 0=8'h80 with others 0, run frame -> rgb=FG_COLOR only at horc 59..65 for vertc 20..27, plus 1-cycle output delay.
REQ-032 cpu_req read addr 8'h10 held across a trigger at vertc=20 -> cpu_gnt low 9 cycles, then high; cpu_rvalid next cycle with RAM contents.
REQ-033 CPU write 8'hFF to addr 8'hF8 -> vertc 268..275 shows FG_COLOR at horc 59..114.
REQ-034 Count frame_tick pulses over 3 frames -> exactly 3, each at horc==0 and vertc==276.
REQ-035 Assert rst_n=0 on 4th fetch cycle -> all outputs at reset values; the next line fetches all 8 bytes correctly.

Source files
------------

// File: rtl/fb_scanout_ctrl.sv
// fb_scanout_ctrl: CHIP-8 64x32 framebuffer scan-out for an LCD timing generator.
// Each CHIP-8 pixel is shown as 7x8 LCD pixels in a 448x256 window at (H_OFF, V_OFF).
// At horc==0 of every window line, the 8 bytes of the current CHIP-8 row are
// fetched into a 64-bit line buffer. Between fetches, a CPU port may access the
// single-port framebuffer RAM.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   horc, vertc, de, hsync,    timing-generator counters and strobes
//   vsync
//   de_o, hsync_o, vsync_o,    strobes delayed one cycle, aligned with rgb
//   rgb                        registered RGB565 pixel
//   frame_tick                 one-cycle pulse per frame, aligned with the delayed
//                              strobes (follows the horc==0, vertc==V_OFF+256 cycle)
//   fb_addr/fb_we/fb_wdata,    framebuffer RAM port (1-cycle synchronous read)
//   fb_rdata
//   cpu_req/cpu_we/cpu_addr/   CPU request, held until cpu_gnt
//   cpu_wdata
//   cpu_gnt/cpu_rdata/         grant (combinational) and read return one cycle later
//   cpu_rvalid
module fb_scanout_ctrl #(
  parameter int unsigned H_OFF    = 59,
  parameter int unsigned V_OFF    = 20,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  horc,
  input  logic [9:0]  vertc,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [15:0] rgb,
  output logic        frame_tick,
  output logic [7:0]  fb_addr,
  output logic        fb_we,
  output logic [7:0]  fb_wdata,
  input  logic [7:0]  fb_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid
);

  localparam logic [10:0] HStart = 11'(H_OFF);
  localparam logic [10:0] HEnd   = 11'(H_OFF + 448);
  localparam logic [10:0] VStart = 11'(V_OFF);
  localparam logic [10:0] VEnd   = 11'(V_OFF + 256);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [2:0]  idx_q, idx_d;
  logic        ld_vld_q, ld_vld_d;
  logic [2:0]  ld_idx_q, ld_idx_d;
  logic [63:0] line_q, line_d;
  logic [2:0]  sub_q, sub_d;
  logic [5:0]  col_q, col_d;
  logic [15:0] rgb_q, rgb_d;
  logic        de_q, hsync_q, vsync_q;
  logic        tick_q, tick_d;
  logic        rvalid_q, rvalid_d;

  logic        v_act, trigger, fetch_rd, in_win;
  logic [4:0]  row_now;
  logic [2:0]  cur_sub;
  logic [5:0]  cur_col;

  assign v_act   = ({1'b0, vertc} >= VStart) && ({1'b0, vertc} < VEnd);
  assign trigger = (horc == '0) && v_act;
  assign row_now = 5'((vertc - 10'(V_OFF)) >> 3);

  // Fetch FSM and RAM port arbitration; the display always wins.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    idx_d    = idx_q;
    fetch_rd = 1'b0;
    cpu_gnt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StFetch;
          row_d   = row_now;
          idx_d   = '0;
        end else begin
          // Gated by rst_n so no grant (and no write) escapes during reset.
          cpu_gnt = cpu_req & rst_n;
        end
      end
      StFetch: begin
        fetch_rd = 1'b1;
        idx_d    = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    fb_addr  = '0;
    fb_we    = 1'b0;
    fb_wdata = '0;
    if (fetch_rd) begin
      fb_addr = {row_q, idx_q};
    end else if (cpu_gnt) begin
      fb_addr  = cpu_addr;
      fb_we    = cpu_we;
      fb_wdata = cpu_wdata;
    end
  end

  // Read data arrives one cycle after each fetch read. The last byte lands in the
  // cycle right after FETCH, still long before the window starts at H_OFF.
  always_comb begin
    line_d   = line_q;
    ld_vld_d = fetch_rd;
    ld_idx_d = idx_q;
    // Byte k occupies line bits [63-8k -: 8], so line_q[63-c] is column c.
    if (ld_vld_q) line_d[{~ld_idx_q, 3'b000} +: 8] = fb_rdata;
  end

  // Column tracking: 7 LCD pixels per CHIP-8 column, restarted at H_OFF.
  always_comb begin
    cur_sub = (({1'b0, horc}) == HStart) ? 3'd0 : sub_q;
    cur_col = (({1'b0, horc}) == HStart) ? 6'd0 : col_q;
    if (cur_sub == 3'd6) begin
      sub_d = 3'd0;
      col_d = cur_col + 6'd1;
    end else begin
      sub_d = cur_sub + 3'd1;
      col_d = cur_col;
    end
  end

  assign in_win = de && v_act && ({1'b0, horc} >= HStart) && ({1'b0, horc} < HEnd);

  always_comb begin
    rgb_d    = (in_win && line_q[~cur_col]) ? FG_COLOR : BG_COLOR;
    tick_d   = (horc == '0) && ({1'b0, vertc} == VEnd);
    rvalid_d = cpu_gnt & ~cpu_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      idx_q    <= '0;
      ld_vld_q <= 1'b0;
      ld_idx_q <= '0;
      line_q   <= '0;
      sub_q    <= '0;
      col_q    <= '0;
      rgb_q    <= BG_COLOR;
      de_q     <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      tick_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      ld_vld_q <= ld_vld_d;
      ld_idx_q <= ld_idx_d;
      line_q   <= line_d;
      sub_q    <= sub_d;
      col_q    <= col_d;
      rgb_q    <= rgb_d;
      de_q     <= de;
      hsync_q  <= hsync;
      vsync_q  <= vsync;
      tick_q   <= tick_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rgb        = rgb_q;
  assign de_o       = de_q;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign frame_tick = tick_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rvalid_q ? fb_rdata : '0;

endmodule

// File: tb/tb_fb_scanout_ctrl.sv
// Directed bench for fb_scanout_ctrl with a behavioural single-port RAM.
module tb_fb_scanout_ctrl;

  localparam logic [15:0] Fg = 16'hFFFF;
  localparam logic [15:0] Bg = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  horc, vertc;
  logic        de, hsync, vsync;
  logic        de_o, hsync_o, vsync_o;
  logic [15:0] rgb;
  logic        frame_tick;
  logic [7:0]  fb_addr, fb_wdata;
  logic        fb_we;
  logic [7:0]  fb_rdata = 8'h00;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;

  logic [7:0]  ram     [256];
  logic [7:0]  exp_mem [256];

  int checks   = 0;
  int errors   = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fb_we) ram[fb_addr] <= fb_wdata;
    fb_rdata <= ram[fb_addr];
  end

  fb_scanout_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .horc       (horc),
    .vertc      (vertc),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .de_o       (de_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .rgb        (rgb),
    .frame_tick (frame_tick),
    .fb_addr    (fb_addr),
    .fb_we      (fb_we),
    .fb_wdata   (fb_wdata),
    .fb_rdata   (fb_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid)
  );

  task automatic set_byte(input int a, input logic [7:0] d);
    ram[a]     <= d;
    exp_mem[a] = d;
  endtask

  // Expected colour of LCD pixel (h, v): 7x8 blow-up of the CHIP-8 framebuffer.
  function automatic logic [15:0] exp_pix(input int h, input int v);
    int col, row;
    logic [7:0] b;
    if (h >= 59 && h < 507 && v >= 20 && v < 276) begin
      col = (h - 59) / 7;
      row = (v - 20) / 8;
      b   = exp_mem[row * 8 + col / 8];
      return b[7 - (col % 8)] ? Fg : Bg;
    end
    return Bg;
  endfunction

  // One full 520-clock line; checks rgb, delayed strobes and frame_tick each cycle.
  task automatic drive_line(input int v);
    logic [15:0] exp_rgb;
    logic [2:0]  exp_strb;
    logic        exp_tick;
    for (int h = 0; h < 520; h++) begin
      horc  = 10'(h);
      vertc = 10'(v);
      de    = (h < 512) && (v < 276);
      hsync = (h >= 512);
      vsync = (v >= 278);
      exp_strb = {de, hsync, vsync};
      @(posedge clk);
      #1;
      exp_rgb  = exp_pix(h, v);
      exp_tick = (h == 0) && (v == 276);
      checks++;
      if (rgb !== exp_rgb) begin
        errors++;
        $display("FAIL rgb v=%0d h=%0d got %h exp %h", v, h, rgb, exp_rgb);
      end
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_strb) begin
        errors++;
        $display("FAIL strobes v=%0d h=%0d got %b exp %b", v, h,
                 {de_o, hsync_o, vsync_o}, exp_strb);
      end
      checks++;
      if (frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL frame_tick v=%0d h=%0d got %b exp %b", v, h, frame_tick, exp_tick);
      end
      if (frame_tick === 1'b1) tick_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    horc = 10'd0; vertc = 10'd20; de = 1'b1; hsync = 1'b1; vsync = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 8'h44;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({rgb, de_o, hsync_o, vsync_o, frame_tick} !== {Bg, 4'b0000}) begin
      errors++;
      $display("FAIL reset_video got %h/%b exp %h/0000", rgb,
               {de_o, hsync_o, vsync_o, frame_tick}, Bg);
    end
    checks++;
    if ({cpu_gnt, cpu_rvalid, fb_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000", {cpu_gnt, cpu_rvalid, fb_we});
    end
    checks++;
    if ({cpu_rdata, fb_addr} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got %h exp 0000", {cpu_rdata, fb_addr});
    end
    horc = 10'd100; cpu_req = 1'b0; cpu_we = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single set bit at byte 0: FG only at horc 59..65, vertc 20..27.
  task automatic test_pixel_window();
    set_byte(0, 8'h80);
    for (int v = 19; v <= 28; v++) drive_line(v);
  endtask

  task automatic test_cpu_read_priority();
    int low;
    logic granted;
    set_byte(8'h10, 8'h5A);
    @(posedge clk);
    #1;
    low = 0;
    granted = 1'b0;
    vertc = 10'd20; de = 1'b1; hsync = 1'b0; vsync = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    for (int k = 0; k < 20; k++) begin
      horc = 10'(k);
      #1;
      if (cpu_gnt === 1'b1) begin
        granted = 1'b1;
        checks++;
        if (fb_addr !== 8'h10) begin
          errors++;
          $display("FAIL gnt_addr got %h exp 10", fb_addr);
        end
      end else begin
        low++;
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if ({fb_we, fb_addr} !== {1'b0, 8'(k - 1)}) begin
          errors++;
          $display("FAIL fetch_addr k=%0d got we=%b addr=%h exp we=0 addr=%h", k, fb_we,
                   fb_addr, 8'(k - 1));
        end
      end
      @(posedge clk);
      #1;
      if (granted) break;
    end
    cpu_req = 1'b0;
    checks++;
    if (granted !== 1'b1) begin
      errors++;
      $display("FAIL gnt_timeout got %b exp 1", granted);
    end
    checks++;
    if (low != 9) begin
      errors++;
      $display("FAIL gnt_low_cycles got %0d exp 9", low);
    end
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL cpu_read got %b/%h exp 1/5a", cpu_rvalid, cpu_rdata);
    end
    horc = 10'd30;
    @(posedge clk);
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_pulse got %b exp 0", cpu_rvalid);
    end
  endtask

  task automatic test_cpu_write();
    horc = 10'd300; vertc = 10'd100; de = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'hF8; cpu_wdata = 8'hFF;
    #1;
    checks++;
    if ({cpu_gnt, fb_we, fb_addr, fb_wdata} !== {2'b11, 8'hF8, 8'hFF}) begin
      errors++;
      $display("FAIL write_port got gnt=%b we=%b addr=%h data=%h exp 1 1 f8 ff", cpu_gnt,
               fb_we, fb_addr, fb_wdata);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    exp_mem[8'hF8] = 8'hFF;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_rvalid got %b exp 0", cpu_rvalid);
    end
    checks++;
    if (ram[8'hF8] !== 8'hFF) begin
      errors++;
      $display("FAIL write_ram got %h exp ff", ram[8'hF8]);
    end
    #1;
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL we_idle got %b exp 0", fb_we);
    end
    for (int v = 267; v <= 276; v++) drive_line(v);
  endtask

  task automatic test_frame_tick();
    tick_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      drive_line(275);
      drive_line(276);
      drive_line(277);
      drive_line(0);
    end
    checks++;
    if (tick_cnt != 3) begin
      errors++;
      $display("FAIL tick_count got %0d exp 3", tick_cnt);
    end
  endtask

  task automatic test_reset_mid_fetch();
    set_byte(8,  8'hA5); set_byte(9,  8'h3C); set_byte(10, 8'h0F); set_byte(11, 8'hF0);
    set_byte(12, 8'h81); set_byte(13, 8'h7E); set_byte(14, 8'h55); set_byte(15, 8'hAA);
    vertc = 10'd28; de = 1'b1; hsync = 1'b1; vsync = 1'b1;
    for (int k = 0; k < 4; k++) begin
      horc = 10'(k);
      @(posedge clk);
      #1;
    end
    horc = 10'd4;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rgb, de_o, hsync_o, vsync_o, frame_tick} !== {Bg, 4'b0000}) begin
      errors++;
      $display("FAIL midreset_video got %h/%b exp %h/0000", rgb,
               {de_o, hsync_o, vsync_o, frame_tick}, Bg);
    end
    checks++;
    if ({cpu_gnt, cpu_rvalid, fb_we, cpu_rdata, fb_addr} !== 19'h0) begin
      errors++;
      $display("FAIL midreset_ctrl got %b/%b/%b/%h/%h exp 0/0/0/00/00", cpu_gnt, cpu_rvalid,
               fb_we, cpu_rdata, fb_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_line(29);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) set_byte(i, 8'h00);
    test_reset();
    test_pixel_window();
    test_cpu_read_priority();
    test_cpu_write();
    test_frame_tick();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
